// File: rtl/kmeans_controller_if.sv
// Pixel-source handshake bundle for kmeans_controller.
// master = pixel store (valid/data), slave = controller (ready/addr).
interface kmeans_controller_if;
  logic        pix_valid;
  logic        pix_ready;
  logic [23:0] pix_data;
  logic [11:0] pix_addr;

  modport master (
    output pix_valid,
    output pix_data,
    input  pix_ready,
    input  pix_addr
  );

  modport slave (
    input  pix_valid,
    input  pix_data,
    output pix_ready,
    output pix_addr
  );
endinterface

// File: rtl/kmeans_controller.sv
// K-means pass sequencer: clear/stream/drain/divide/check; pix via slave modport,
// engine ports eng_*, status busy/done/iter. KMEANS_CONV_CHECK_EN adds early exit.
module kmeans_controller #(
  parameter int T        = 16,
  parameter int NPIX     = 4096,
  parameter int MAX_ITER = 8,
  parameter int PIPE_LAT = 3
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [24*T-1:0]    init_mean,
  kmeans_controller_if.slave pix,
  output logic [23:0]        eng_pixel,
  output logic               eng_clear,
  output logic [15:0]        eng_enabled,
  output logic [24*16-1:0]   eng_mean,
  input  logic [72*T-1:0]    eng_acc,
  input  logic [12*T-1:0]    eng_cnt,
  output logic               busy,
  output logic               done,
  output logic [7:0]         iter
);
  localparam int CW = (T > 1) ? $clog2(T) : 1;
  localparam logic [11:0]   LAST     = 12'(NPIX - 1);
  localparam logic [CW-1:0] CLU_LAST = CW'(T - 1);
  localparam logic [CW-1:0] CLU_ONE  = CW'(1);
  localparam logic [7:0]    DRN_LAST = 8'(PIPE_LAT - 1);
  localparam logic [7:0]    ITER_CAP = 8'(MAX_ITER);
  localparam logic [15:0]   EN_MASK  = 16'((32'd1 << T) - 32'd1);

  typedef enum logic [2:0] {
    S_IDLE, S_CLEAR, S_STREAM, S_DRAIN, S_DIVIDE, S_CHECK
  } state_t;

  state_t state_q, state_d;

  logic [23:0]   mean_q   [T];
  logic [23:0]   shadow_q [T];
  logic [23:0]   shadow_d [T];
  logic [23:0]   acc_a    [T][3];
  logic [11:0]   cnt_a    [T];

  logic [23:0]   pix_q;
  logic [11:0]   addr_q;
  logic [7:0]    drn_q;
  logic [4:0]    bit_q;
  logic [1:0]    ch_q;
  logic [CW-1:0] clu_q;
  logic [11:0]   rem_q;
  logic [23:0]   quo_q;
  logic [7:0]    iter_q;
  logic          done_q;

  logic          xfer, last_xfer, slot_end, last_div, wr_en;
  logic [23:0]   acc_sel, div_in, quo_d;
  logic [11:0]   cnt_sel, rem_in, rem_d;
  logic [12:0]   trial;
  logic          ge;
  logic [7:0]    iter_inc;
  logic          stop;

  for (genvar k = 0; k < T; k++) begin : g_unpack
    assign acc_a[k][0] = eng_acc[72*k+48 +: 24];
    assign acc_a[k][1] = eng_acc[72*k+24 +: 24];
    assign acc_a[k][2] = eng_acc[72*k    +: 24];
    assign cnt_a[k]    = eng_cnt[12*k +: 12];
  end

  for (genvar k = 0; k < 16; k++) begin : g_mean
    if (k < T) begin : g_on
      assign eng_mean[24*k +: 24] = mean_q[k];
    end else begin : g_off
      assign eng_mean[24*k +: 24] = 24'd0;
    end
  end

  assign xfer      = (state_q == S_STREAM) && pix.pix_valid;
  assign last_xfer = xfer && (addr_q == LAST);
  assign slot_end  = (bit_q == 5'd23);
  assign last_div  = slot_end && (ch_q == 2'd2) && (clu_q == CLU_LAST);

  assign pix.pix_ready = (state_q == S_STREAM);
  assign pix.pix_addr  = addr_q;
  assign eng_clear     = (state_q == S_CLEAR);
  assign eng_enabled   = xfer ? EN_MASK : 16'd0;
  assign eng_pixel     = xfer ? pix.pix_data : pix_q;
  assign busy          = (state_q != S_IDLE);
  assign done          = done_q;
  assign iter          = iter_q;

  // Restoring divider step; slot start takes operands straight from the
  // engine so each quotient costs exactly 24 cycles.
  always_comb begin
    acc_sel = acc_a[clu_q][ch_q];
    cnt_sel = cnt_a[clu_q];
    div_in  = (bit_q == 5'd0) ? acc_sel : quo_q;
    rem_in  = (bit_q == 5'd0) ? 12'd0 : rem_q;
    trial   = {rem_in, div_in[23]};
    ge      = (trial >= {1'b0, cnt_sel});
    rem_d   = ge ? 12'(trial - {1'b0, cnt_sel}) : trial[11:0];
    quo_d   = {div_in[22:0], ge};
  end

  assign wr_en = (state_q == S_DIVIDE) && slot_end && (cnt_sel != 12'd0);

  always_comb begin
    for (int k = 0; k < T; k++) shadow_d[k] = shadow_q[k];
    if (wr_en) begin
      case (ch_q)
        2'd0:    shadow_d[clu_q][23:16] = quo_d[7:0];
        2'd1:    shadow_d[clu_q][15:8]  = quo_d[7:0];
        default: shadow_d[clu_q][7:0]   = quo_d[7:0];
      endcase
    end
  end

`ifdef KMEANS_CONV_CHECK_EN
  logic conv_d, conv_q;

  always_comb begin
    conv_d = 1'b1;
    for (int k = 0; k < T; k++)
      if (shadow_d[k] != mean_q[k]) conv_d = 1'b0;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) conv_q <= 1'b0;
    else if (state_q == S_DIVIDE && last_div) conv_q <= conv_d;
  end
`endif

  always_comb begin
    state_d  = state_q;
    iter_inc = (iter_q == 8'hFF) ? iter_q : iter_q + 8'd1;
    stop     = (iter_inc == ITER_CAP);
`ifdef KMEANS_CONV_CHECK_EN
    stop     = stop | conv_q;
`endif
    unique case (state_q)
      S_IDLE:   if (start) state_d = S_CLEAR;
      S_CLEAR:  state_d = S_STREAM;
      S_STREAM: if (last_xfer) state_d = S_DRAIN;
      S_DRAIN:  if (drn_q == DRN_LAST) state_d = S_DIVIDE;
      S_DIVIDE: if (last_div) state_d = S_CHECK;
      S_CHECK:  state_d = stop ? S_IDLE : S_CLEAR;
      default:  state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      pix_q   <= '0;
      addr_q  <= '0;
      drn_q   <= '0;
      bit_q   <= '0;
      ch_q    <= '0;
      clu_q   <= '0;
      rem_q   <= '0;
      quo_q   <= '0;
      iter_q  <= '0;
      done_q  <= 1'b0;
      for (int k = 0; k < T; k++) begin
        mean_q[k]   <= '0;
        shadow_q[k] <= '0;
      end
    end else begin
      state_q <= state_d;
      done_q  <= 1'b0;
      if (state_q == S_IDLE && start) begin
        iter_q <= '0;
        for (int k = 0; k < T; k++) begin
          mean_q[k]   <= init_mean[24*k +: 24];
          shadow_q[k] <= init_mean[24*k +: 24];
        end
      end
      if (state_q == S_IDLE || state_q == S_CHECK) addr_q <= '0;
      if (xfer) begin
        pix_q <= pix.pix_data;
        if (!last_xfer) addr_q <= addr_q + 12'd1;
      end
      drn_q <= (state_q == S_DRAIN) ? drn_q + 8'd1 : 8'd0;
      if (state_q == S_DIVIDE) begin
        rem_q    <= rem_d;
        quo_q    <= quo_d;
        shadow_q <= shadow_d;
        bit_q    <= slot_end ? 5'd0 : bit_q + 5'd1;
        if (slot_end) begin
          ch_q <= (ch_q == 2'd2) ? 2'd0 : ch_q + 2'd1;
          if (ch_q == 2'd2)
            clu_q <= (clu_q == CLU_LAST) ? '0 : clu_q + CLU_ONE;
        end
        // Means switch in one step as DIVIDE hands over to CHECK.
        if (last_div) mean_q <= shadow_d;
      end
      if (state_q == S_CHECK) begin
        iter_q <= iter_inc;
        done_q <= stop;
      end
    end
  end
endmodule

// File: tb/tb_kmeans_controller.sv
// Self-checking bench for kmeans_controller (T=2, NPIX=4) with an
// engine model and an arithmetic k-means reference.
`timescale 1ns/1ps
module tb_kmeans_controller;
  localparam int T        = 2;
  localparam int NPIX     = 4;
  localparam int MAX_ITER = 8;
  localparam int PIPE_LAT = 3;
  localparam int PASS_CYC = 1 + NPIX + PIPE_LAT + 72 * T + 1;
  localparam int LIMIT    = 6000;
`ifdef KMEANS_CONV_CHECK_EN
  localparam bit CONV = 1'b1;
`else
  localparam bit CONV = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             reset = 1'b0;
  logic             start = 1'b0;
  logic [24*T-1:0]  init_mean = '0;
  logic [23:0]      eng_pixel;
  logic             eng_clear;
  logic [15:0]      eng_enabled;
  logic [24*16-1:0] eng_mean;
  logic [72*T-1:0]  eng_acc;
  logic [12*T-1:0]  eng_cnt;
  logic             busy, done;
  logic [7:0]       iter;

  kmeans_controller_if pif ();

  kmeans_controller #(
    .T(T), .NPIX(NPIX), .MAX_ITER(MAX_ITER), .PIPE_LAT(PIPE_LAT)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .init_mean(init_mean),
    .pix(pif.slave), .eng_pixel(eng_pixel), .eng_clear(eng_clear),
    .eng_enabled(eng_enabled), .eng_mean(eng_mean), .eng_acc(eng_acc),
    .eng_cnt(eng_cnt), .busy(busy), .done(done), .iter(iter)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input longint obs, input longint exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int nearest(input int p [3], input int m [T][3]);
    int best, bd, d;
    best = 0;
    bd = -1;
    for (int k = 0; k < T; k++) begin
      d = 0;
      for (int c = 0; c < 3; c++) d += (p[c] - m[k][c]) * (p[c] - m[k][c]);
      if (bd < 0 || d < bd) begin
        bd = d;
        best = k;
      end
    end
    return best;
  endfunction

  function automatic int engine_pick(input logic [23:0] px,
                                     input logic [24*16-1:0] mm);
    int p [3];
    int m [T][3];
    for (int c = 0; c < 3; c++) begin
      p[c] = int'(px[16-8*c +: 8]);
      for (int k = 0; k < T; k++) m[k][c] = int'(mm[24*k+16-8*c +: 8]);
    end
    return nearest(p, m);
  endfunction

  // Engine model: nearest-mean assignment and per-cluster sums.
  int e_sum [T][3];
  int e_cnt [T];
  int e_pick;

  always_comb e_pick = engine_pick(eng_pixel, eng_mean);

  always @(posedge clk) begin
    if (eng_clear) begin
      for (int k = 0; k < T; k++) begin
        e_cnt[k] <= 0;
        for (int c = 0; c < 3; c++) e_sum[k][c] <= 0;
      end
    end else if (eng_enabled[0]) begin
      e_cnt[e_pick] <= e_cnt[e_pick] + 1;
      for (int c = 0; c < 3; c++)
        e_sum[e_pick][c] <= e_sum[e_pick][c] + int'(eng_pixel[16-8*c +: 8]);
    end
  end

  always_comb begin
    eng_acc = '0;
    eng_cnt = '0;
    for (int k = 0; k < T; k++) begin
      eng_cnt[12*k +: 12] = 12'(e_cnt[k]);
      for (int c = 0; c < 3; c++)
        eng_acc[72*k+48-24*c +: 24] = 24'(e_sum[k][c]);
    end
  end

  // Protocol monitor.
  int xfers, viol_en, viol_px, viol_addr, done_pulses, clr_cnt;

  always @(negedge clk) begin
    if (pif.pix_valid && pif.pix_ready) begin
      xfers++;
      if (eng_enabled !== 16'h0003) viol_en++;
      if (eng_pixel !== pif.pix_data) viol_px++;
    end else if (eng_enabled !== 16'h0000) begin
      viol_en++;
    end
    if (int'(pif.pix_addr) > NPIX - 1) viol_addr++;
    if (done) done_pulses++;
    if (eng_clear) clr_cnt++;
  end

  // Reference k-means.
  int px_mem [NPIX][3];
  int seed   [T][3];
  int exp_m1 [T][3];
  int exp_fin[T][3];
  int exp_iters;

  task automatic ref_model();
    int m [T][3];
    int nm [T][3];
    int s [T][3];
    int c [T];
    int b;
    bit same;
    m = seed;
    nm = seed;
    exp_iters = 0;
    for (int it = 1; it <= MAX_ITER; it++) begin
      for (int k = 0; k < T; k++) begin
        c[k] = 0;
        for (int h = 0; h < 3; h++) s[k][h] = 0;
      end
      for (int p = 0; p < NPIX; p++) begin
        b = nearest(px_mem[p], m);
        c[b]++;
        for (int h = 0; h < 3; h++) s[b][h] += px_mem[p][h];
      end
      same = 1'b1;
      for (int k = 0; k < T; k++)
        for (int h = 0; h < 3; h++) begin
          nm[k][h] = (c[k] != 0) ? s[k][h] / c[k] : m[k][h];
          if (nm[k][h] != m[k][h]) same = 1'b0;
        end
      if (it == 1) exp_m1 = nm;
      exp_iters = it;
      if (CONV && same) break;
      m = nm;
    end
    exp_fin = nm;
  endtask

  function automatic logic [23:0] pack3(input int a, input int b, input int c);
    return {a[7:0], b[7:0], c[7:0]};
  endfunction

  function automatic logic [23:0] pix_word(input logic [11:0] a);
    if (int'(a) < NPIX)
      return pack3(px_mem[a][0], px_mem[a][1], px_mem[a][2]);
    return 24'd0;
  endfunction

  task automatic drive(input int mode, input int cyc);
    if (mode == 0) pif.pix_valid = 1'b1;
    else if (mode == 1) pif.pix_valid = (cyc % 2 == 0);
    else pif.pix_valid = ($urandom_range(0, 1) == 1);
    pif.pix_data = pix_word(pif.pix_addr);
  endtask

  task automatic load_seeds();
    for (int k = 0; k < T; k++)
      init_mean[24*k +: 24] = pack3(seed[k][0], seed[k][1], seed[k][2]);
  endtask

  logic [24*T-1:0] snap1;

  task automatic run(input int mode, input bit poke, output int cyc);
    bit got1;
    got1 = 1'b0;
    cyc = 0;
    snap1 = '0;
    @(negedge clk);
    #1;
    xfers = 0; viol_en = 0; viol_px = 0; viol_addr = 0;
    done_pulses = 0; clr_cnt = 0;
    load_seeds();
    start = 1'b1;
    drive(mode, 0);
    while (cyc < LIMIT) begin
      @(posedge clk);
      cyc++;
      @(negedge clk);
      start = poke && (cyc == 40 || cyc == 300);
      if (iter == 8'd1 && !got1) begin
        got1 = 1'b1;
        snap1 = eng_mean[24*T-1:0];
      end
      if (done) break;
      drive(mode, cyc);
    end
    start = 1'b0;
    pif.pix_valid = 1'b0;
    repeat (3) @(negedge clk);
    #1;
  endtask

  task automatic verify(input string tag, input int cyc, input bit timed);
    logic [24*T-1:0] e1;
    for (int k = 0; k < T; k++)
      e1[24*k +: 24] = pack3(exp_m1[k][0], exp_m1[k][1], exp_m1[k][2]);
    check({tag, " finished"}, longint'(cyc < LIMIT), 1);
    check({tag, " iter"}, iter, exp_iters);
    check({tag, " mean_after_1"}, snap1, e1);
    for (int k = 0; k < T; k++)
      check($sformatf("%s mean%0d", tag, k), eng_mean[24*k +: 24],
            pack3(exp_fin[k][0], exp_fin[k][1], exp_fin[k][2]));
    check({tag, " unused_slots"}, longint'(|eng_mean[383:24*T]), 0);
    check({tag, " done_pulses"}, done_pulses, 1);
    check({tag, " busy_after"}, busy, 0);
    check({tag, " enable_rule"}, viol_en, 0);
    check({tag, " eng_pixel"}, viol_px, 0);
    check({tag, " addr_range"}, viol_addr, 0);
    check({tag, " transfers"}, xfers, exp_iters * NPIX);
    check({tag, " clears"}, clr_cnt, exp_iters);
    if (timed) check({tag, " cycles"}, cyc, exp_iters * PASS_CYC + 1);
  endtask

  task automatic set_gray(input int idx, input int v);
    for (int h = 0; h < 3; h++) px_mem[idx][h] = v;
  endtask

  int cyc;

  initial begin
    pif.pix_valid = 1'b0;
    pif.pix_data  = '0;
    reset = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check("rst busy", busy, 0);
    check("rst done", done, 0);
    check("rst pix_ready", pif.pix_ready, 0);
    check("rst eng_clear", eng_clear, 0);
    check("rst eng_enabled", eng_enabled, 0);
    check("rst eng_pixel", eng_pixel, 0);
    check("rst pix_addr", pif.pix_addr, 0);
    check("rst iter", iter, 0);
    check("rst eng_mean", longint'(|eng_mean), 0);
    reset = 1'b1;
    repeat (2) @(negedge clk);

    // Two far-apart seeds, three dark and one bright pixel.
    for (int h = 0; h < 3; h++) begin
      seed[0][h] = 0;
      seed[1][h] = 255;
    end
    for (int p = 0; p < 3; p++) set_gray(p, 10);
    set_gray(3, 250);
    ref_model();
    check("ref m1 c0", pack3(exp_m1[0][0], exp_m1[0][1], exp_m1[0][2]),
          24'h0A0A0A);
    check("ref m1 c1", pack3(exp_m1[1][0], exp_m1[1][1], exp_m1[1][2]),
          24'hFAFAFA);
    check("ref iters", exp_iters, CONV ? 2 : MAX_ITER);
    run(0, 1'b0, cyc);
    verify("A_valid_high", cyc, 1'b1);
    run(1, 1'b0, cyc);
    verify("B_valid_toggle", cyc, 1'b0);
    run(0, 1'b1, cyc);
    verify("C_start_while_busy", cyc, 1'b1);

    // Second cluster never attracts a pixel.
    for (int p = 0; p < 3; p++) set_gray(p, 10);
    set_gray(3, 20);
    ref_model();
    run(0, 1'b0, cyc);
    verify("D_empty_cluster", cyc, 1'b1);

    // Randomised data, random or toggled pixel handshake.
    for (int r = 0; r < 4; r++) begin
      for (int k = 0; k < T; k++)
        for (int h = 0; h < 3; h++) seed[k][h] = int'($urandom_range(0, 255));
      for (int p = 0; p < NPIX; p++)
        for (int h = 0; h < 3; h++) px_mem[p][h] = int'($urandom_range(0, 255));
      ref_model();
      run((r % 2 == 0) ? 2 : 1, 1'b0, cyc);
      verify($sformatf("R%0d_random", r), cyc, 1'b0);
    end

    // Reset during the second pass's DIVIDE phase.
    for (int h = 0; h < 3; h++) begin
      seed[0][h] = 0;
      seed[1][h] = 255;
    end
    for (int p = 0; p < 3; p++) set_gray(p, 10);
    set_gray(3, 250);
    ref_model();
    @(negedge clk);
    #1;
    done_pulses = 0;
    load_seeds();
    start = 1'b1;
    drive(0, 0);
    for (int i = 1; i <= 220; i++) begin
      @(negedge clk);
      start = 1'b0;
      drive(0, i);
    end
    #1;
    check("mid iter_before", iter, 1);
    reset = 1'b0;
    #1;
    check("mid busy", busy, 0);
    check("mid eng_mean", longint'(|eng_mean), 0);
    check("mid iter", iter, 0);
    check("mid pix_ready", pif.pix_ready, 0);
    pif.pix_valid = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    #1;
    check("mid idle_after", busy, 0);
    check("mid no_done", done_pulses, 0);
    run(0, 1'b0, cyc);
    verify("E_after_reset", cyc, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
